// File: rtl/cselector_sched.sv
// cselector_sched: credit-gated round-robin scheduler driving a 4-way selector
// through an IDLE/DRIVE/WAIT handshake with a wait-for-free watchdog.
module cselector_sched #(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_CREDIT = 2,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [NUM_PORTS-1:0] o_select,
  output logic                 o_drive,
  input  logic                 i_free,
  input  logic [NUM_PORTS-1:0] i_credit_ret,
  output logic                 o_busy,
  output logic                 o_timeout,
  input  logic                 i_timeout_clr
);
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;
  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] sel_q, sel_d, elig, pick;
  logic [PW-1:0]        ptr_q, ptr_d, idx, gidx;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d, abort, dec;
  logic [1:0]           cr_q [NUM_PORTS];
  logic [1:0]           cr_d [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= PW'(NUM_PORTS - 1);
      wd_q      <= '0;
      timeout_q <= 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) cr_q[k] <= 2'(MAX_CREDIT);
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      for (int k = 0; k < NUM_PORTS; k++) cr_q[k] <= cr_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    abort   = 1'b0;
    pick    = '0;
    idx     = '0;
    gidx    = '0;
    dec     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) elig[k] = i_req[k] && cr_q[k] != 2'd0;
    // first eligible port scanning upward from ptr+1
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PW'((int'(ptr_q) + i) % NUM_PORTS);
      if (pick == '0 && elig[idx]) pick[idx] = 1'b1;
    end
    for (int k = 0; k < NUM_PORTS; k++) if (sel_q[k]) gidx = PW'(k);
    case (state_q)
      IDLE: if (|pick) begin
        sel_d   = pick;
        state_d = DRIVE;
      end
      DRIVE: state_d = WAIT;
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (i_free) begin
          state_d = IDLE;
          sel_d   = '0;
          ptr_d   = gidx;
        end else if (&wd_d) begin
          abort   = 1'b1;
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    timeout_d = i_timeout_clr ? 1'b0 : (abort | timeout_q);
    for (int k = 0; k < NUM_PORTS; k++) begin
      dec     = state_q == DRIVE && sel_q[k];
      cr_d[k] = (dec && !i_credit_ret[k]) ? cr_q[k] - 2'd1 :
                (i_credit_ret[k] && !dec && cr_q[k] != 2'(MAX_CREDIT)) ? cr_q[k] + 2'd1 : cr_q[k];
    end
  end

  always_comb begin
    o_busy    = state_q != IDLE;
    o_drive   = state_q == DRIVE;
    o_select  = sel_q;
    o_gnt     = o_drive ? sel_q : '0;
    o_timeout = timeout_q;
  end
endmodule

// File: tb/tb_cselector_sched.sv
// tb_cselector_sched: table-driven vectors plus watchdog and reset sequences.
module tb_cselector_sched;
  logic       clk = 1'b0;
  logic       rst, i_free, i_timeout_clr, o_drive, o_busy, o_timeout;
  logic [3:0] i_req, i_credit_ret, o_gnt, o_select;
  int         n_chk = 0;
  int         n_fail = 0;

  localparam logic [1:0] I = 2'd0, D = 2'd1, W = 2'd2;

  typedef struct {
    logic [3:0] req;
    logic       free;
    logic [3:0] cret;
    logic [3:0] sel;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [33];

  always #5 clk = ~clk;

  cselector_sched dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .o_select(o_select),
    .o_drive(o_drive), .i_free(i_free), .i_credit_ret(i_credit_ret),
    .o_busy(o_busy), .o_timeout(o_timeout), .i_timeout_clr(i_timeout_clr)
  );

  function automatic vec_t mk(logic [3:0] req, logic free, logic [3:0] cret, logic [3:0] sel, logic [1:0] st);
    vec_t v;
    v.req = req; v.free = free; v.cret = cret; v.sel = sel; v.st = st;
    return v;
  endfunction

  task automatic step(input logic [3:0] req, input logic free, input logic [3:0] cret, input logic clr, input logic r);
    i_req = req; i_free = free; i_credit_ret = cret; i_timeout_clr = clr; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] sel, input logic [1:0] st, input logic to);
    logic [10:0] exp, act;
    exp = {(st == D) ? sel : 4'b0000, sel, st == D, st != I, to};
    act = {o_gnt, o_select, o_drive, o_busy, o_timeout};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b sel=%b drive=%b busy=%b timeout=%b, expected gnt=%b sel=%b drive=%b busy=%b timeout=%b",
               name, act[10:7], act[6:3], act[2], act[1], act[0], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic watchdog(input string name, input logic [3:0] sel, input logic clr);
    for (int i = 0; i < 255; i++) begin
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk($sformatf("%s_wait%0d", name, i), sel, W, 1'b0);
    end
    step(4'b0000, 1'b0, 4'b0000, clr, 1'b0);
    chk($sformatf("%s_abort", name), 4'b0000, I, !clr);
  endtask

  initial begin
    tbl[0]  = mk(4'b0001, 0, 4'b0000, 4'b0001, D);
    tbl[1]  = mk(4'b0000, 0, 4'b0000, 4'b0001, W);
    tbl[2]  = mk(4'b0000, 1, 4'b0000, 4'b0000, I);
    tbl[3]  = mk(4'b1111, 0, 4'b0000, 4'b0010, D);
    tbl[4]  = mk(4'b1111, 1, 4'b0000, 4'b0010, W);
    tbl[5]  = mk(4'b1111, 1, 4'b0000, 4'b0000, I);
    tbl[6]  = mk(4'b1111, 0, 4'b0000, 4'b0100, D);
    tbl[7]  = mk(4'b1111, 0, 4'b0000, 4'b0100, W);
    tbl[8]  = mk(4'b1111, 1, 4'b0000, 4'b0000, I);
    tbl[9]  = mk(4'b1111, 0, 4'b0000, 4'b1000, D);
    tbl[10] = mk(4'b1111, 0, 4'b0000, 4'b1000, W);
    tbl[11] = mk(4'b1111, 1, 4'b0000, 4'b0000, I);
    tbl[12] = mk(4'b1111, 0, 4'b0000, 4'b0001, D);
    tbl[13] = mk(4'b1111, 0, 4'b0000, 4'b0001, W);
    tbl[14] = mk(4'b0001, 1, 4'b0000, 4'b0000, I);
    tbl[15] = mk(4'b0001, 0, 4'b0000, 4'b0000, I);
    tbl[16] = mk(4'b0001, 0, 4'b0001, 4'b0000, I);
    tbl[17] = mk(4'b0001, 0, 4'b0000, 4'b0001, D);
    tbl[18] = mk(4'b0001, 0, 4'b0001, 4'b0001, W);
    tbl[19] = mk(4'b0001, 1, 4'b0000, 4'b0000, I);
    tbl[20] = mk(4'b0001, 0, 4'b0000, 4'b0001, D);
    tbl[21] = mk(4'b0001, 0, 4'b0000, 4'b0001, W);
    tbl[22] = mk(4'b0001, 1, 4'b0000, 4'b0000, I);
    tbl[23] = mk(4'b0001, 0, 4'b0000, 4'b0000, I);
    tbl[24] = mk(4'b0000, 0, 4'b0010, 4'b0000, I);
    tbl[25] = mk(4'b0000, 0, 4'b0010, 4'b0000, I);
    tbl[26] = mk(4'b0010, 0, 4'b0000, 4'b0010, D);
    tbl[27] = mk(4'b0010, 0, 4'b0000, 4'b0010, W);
    tbl[28] = mk(4'b0010, 1, 4'b0000, 4'b0000, I);
    tbl[29] = mk(4'b0010, 0, 4'b0000, 4'b0010, D);
    tbl[30] = mk(4'b0010, 0, 4'b0000, 4'b0010, W);
    tbl[31] = mk(4'b0010, 1, 4'b0000, 4'b0000, I);
    tbl[32] = mk(4'b0010, 0, 4'b0000, 4'b0000, I);

    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    chk("reset", 4'b0000, I, 1'b0);

    for (int i = 0; i < 33; i++) begin
      step(tbl[i].req, tbl[i].free, tbl[i].cret, 1'b0, 1'b0);
      chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].st, 1'b0);
    end

    step(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("wd1_drive", 4'b0100, D, 1'b0);
    watchdog("wd1", 4'b0100, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("wd1_no_credit_restore", 4'b0000, I, 1'b1);
    step(4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0);
    chk("wd1_clear", 4'b0000, I, 1'b0);
    step(4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0);
    chk("ret_port1", 4'b0000, I, 1'b0);
    step(4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("ptr_not_advanced", 4'b0100, D, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("ptr_wait", 4'b0100, W, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("ptr_free", 4'b0000, I, 1'b0);

    step(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("wd2_drive", 4'b0010, D, 1'b0);
    watchdog("wd2_clr_prio", 4'b0010, 1'b1);

    step(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_drive", 4'b1000, D, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_wait", 4'b1000, W, 1'b0);
    step(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1);
    chk("rst_mid_wait", 4'b0000, I, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("rst_late_free", 4'b0000, I, 1'b0);
    step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_ptr_port0", 4'b0001, D, 1'b0);
    step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_wait2", 4'b0001, W, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("rst_free2", 4'b0000, I, 1'b0);
    step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_credit_full", 4'b0001, D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
